// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU control codes and FSM state encoding.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMREAD  = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWRITE = 4'd5;
   localparam logic [3:0] ST_EXECUTE  = 4'd6;
   localparam logic [3:0] ST_ALUWB    = 4'd7;
   localparam logic [3:0] ST_BRANCH   = 4'd8;
   localparam logic [3:0] ST_ADDIEXEC = 4'd9;
   localparam logic [3:0] ST_ADDIWB   = 4'd10;
   localparam logic [3:0] ST_JUMP     = 4'd11;

   typedef enum logic [3:0] {
      S_FETCH    = ST_FETCH,
      S_DECODE   = ST_DECODE,
      S_MEMADR   = ST_MEMADR,
      S_MEMREAD  = ST_MEMREAD,
      S_MEMWB    = ST_MEMWB,
      S_MEMWRITE = ST_MEMWRITE,
      S_EXECUTE  = ST_EXECUTE,
      S_ALUWB    = ST_ALUWB,
      S_BRANCH   = ST_BRANCH,
      S_ADDIEXEC = ST_ADDIEXEC,
      S_ADDIWB   = ST_ADDIWB,
      S_JUMP     = ST_JUMP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the controller's ALU operation class and funct field to
// the ALU control code; o_valid drops on an unsupported funct.
module alu_decoder
   import mc_pkg::*;
(
   input  alu_op_t     i_alu_op,
   input  logic [5:0]  i_funct,
   output logic [2:0]  o_alu_control,
   output logic        o_valid
);

   always_comb begin
      o_alu_control = ALU_ADD;
      o_valid       = 1'b1;
      case (i_alu_op)
         ALUOP_ADD: o_alu_control = ALU_ADD;
         ALUOP_SUB: o_alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               FN_ADD:  o_alu_control = ALU_ADD;
               FN_SUB:  o_alu_control = ALU_SUB;
               FN_AND:  o_alu_control = ALU_AND;
               FN_OR:   o_alu_control = ALU_OR;
               FN_SLT:  o_alu_control = ALU_SLT;
               default: o_valid = 1'b0;
            endcase
         end
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM with memory-latency wait counter;
// all datapath controls decode combinationally from state, wcnt and op/funct.
//
// state    | meaning
// FETCH    | read instr at PC; after MEM_RD_LAT waits load IR, PC += 4
// DECODE   | precompute branch target into ALUOut, dispatch on op
// MEMADR   | compute A + SignImm for lw/sw
// MEMREAD  | hold data address, wait MEM_RD_LAT cycles
// MEMWB    | write loaded data into rt
// MEMWRITE | single-cycle store
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALUOut into rd
// BRANCH   | compare A-B, conditional PC load from ALUOut
// ADDIEXEC | compute A + SignImm
// ADDIWB   | write ALUOut into rt
// JUMP     | load PC with jump target
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output logic        pc_write,
   output logic        branch,
   output logic [1:0]  pc_src,
   output logic [2:0]  alu_control,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        iord,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        illegal_op,
   output logic [3:0]  state_dbg
);

   localparam logic [1:0] LAT = 2'(MEM_RD_LAT);

   state_t      r_state;
   logic [1:0]  r_wcnt;
   alu_op_t     w_alu_op;
   logic [2:0]  w_alu_control;
   logic        w_alu_valid;
   logic        w_wait_done;
   logic        w_op_legal;

   assign w_wait_done = (r_wcnt == LAT);
   assign w_op_legal  = op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
   assign w_alu_op    = (r_state == S_EXECUTE) ? ALUOP_FUNCT :
                        (r_state == S_BRANCH)  ? ALUOP_SUB   : ALUOP_ADD;

   alu_decoder u_alu_decoder (
      .i_alu_op      (w_alu_op),
      .i_funct       (funct),
      .o_alu_control (w_alu_control),
      .o_valid       (w_alu_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_wcnt  <= 2'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_wait_done) begin
                  r_wcnt  <= 2'd0;
                  r_state <= S_DECODE;
               end else begin
                  r_wcnt <= r_wcnt + 2'd1;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_RTYPE:     r_state <= S_EXECUTE;
                  OP_BEQ:       r_state <= S_BRANCH;
                  OP_ADDI:      r_state <= S_ADDIEXEC;
                  OP_J:         r_state <= S_JUMP;
                  default:      r_state <= S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (op == OP_SW)      r_state <= S_MEMWRITE;
               else if (op == OP_LW) r_state <= S_MEMREAD;
               else                  r_state <= S_FETCH;
            end
            S_MEMREAD: begin
               if (w_wait_done) begin
                  r_wcnt  <= 2'd0;
                  r_state <= S_MEMWB;
               end else begin
                  r_wcnt <= r_wcnt + 2'd1;
               end
            end
            S_EXECUTE:  r_state <= w_alu_valid ? S_ALUWB : S_FETCH;
            S_ADDIEXEC: r_state <= S_ADDIWB;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      pc_src      = 2'b00;
      alu_control = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal_op  = 1'b0;
      case (r_state)
         S_FETCH: begin
            alu_src_b = 2'b01;
            ir_write  = w_wait_done;
            pc_write  = w_wait_done;
         end
         S_DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = !w_op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMREAD: iord = 1'b1;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a   = 1'b1;
            alu_control = w_alu_control;
            illegal_op  = !w_alu_valid;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = w_alu_control;
            branch      = 1'b1;
            pc_src      = 2'b01;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         default: ;
      endcase
   end

   assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_RD_LAT=1): per-instruction vector
// table of state sequences and key-cycle outputs, plus reset corner cases.
module tb_mc_control_fsm;
   import mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  op, funct;
   logic        pc_write, branch, alu_src_a, iord, mem_write, ir_write;
   logic        reg_write, reg_dst, mem_to_reg, illegal_op;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_control;
   logic [3:0]  state_dbg;
   logic [16:0] w_key;

   int n_checks = 0;
   int n_fail   = 0;

   typedef logic [3:0] sarr_t [8];
   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      int          len;
      sarr_t       seq;
      int          key_idx;
      logic [16:0] key;
      int          n_rw;
      int          n_mw;
      int          n_ill;
   } vec_t;

   vec_t vecs[$];

   localparam logic [3:0] F  = ST_FETCH,   D  = ST_DECODE,  MA = ST_MEMADR;
   localparam logic [3:0] MR = ST_MEMREAD, MB = ST_MEMWB,   MW = ST_MEMWRITE;
   localparam logic [3:0] EX = ST_EXECUTE, AW = ST_ALUWB,   BR = ST_BRANCH;
   localparam logic [3:0] AE = ST_ADDIEXEC, AB = ST_ADDIWB, JP = ST_JUMP;

   mc_control_fsm #(.MEM_RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
      .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign w_key = {pc_write, branch, pc_src, alu_control, alu_src_a, alu_src_b,
                   iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op};

   function automatic logic [16:0] kv(input logic pcw, input logic br, input logic [1:0] pcs,
                                      input logic [2:0] alu, input logic sa, input logic [1:0] sb,
                                      input logic io, input logic mw, input logic irw,
                                      input logic rw, input logic rd, input logic m2r,
                                      input logic ill);
      return {pcw, br, pcs, alu, sa, sb, io, mw, irw, rw, rd, m2r, ill};
   endfunction

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input int len,
                               input sarr_t seq, input int kidx, input logic [16:0] key,
                               input int rw, input int mw, input int ill);
      vec_t v;
      v.op = o; v.funct = f; v.len = len; v.seq = seq; v.key_idx = kidx;
      v.key = key; v.n_rw = rw; v.n_mw = mw; v.n_ill = ill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int rw = 0, mw = 0, ill = 0, irw = 0;
      op = v.op; funct = v.funct;
      for (int i = 0; i < v.len; i++) begin
         #1;
         chk($sformatf("v%0d_state_c%0d", idx, i), 32'(state_dbg), 32'(v.seq[i]));
         if (i == v.key_idx) chk($sformatf("v%0d_key_c%0d", idx, i), 32'(w_key), 32'(v.key));
         chk($sformatf("v%0d_inv_pcw_br", idx), 32'(pc_write & branch), 32'd0);
         chk($sformatf("v%0d_inv_wr_excl", idx),
             32'($countones({mem_write, reg_write, ir_write}) > 1), 32'd0);
         rw  += int'(reg_write);
         mw  += int'(mem_write);
         ill += int'(illegal_op);
         irw += int'(ir_write);
         @(negedge clk);
      end
      #1;
      chk($sformatf("v%0d_ret_fetch", idx), 32'(state_dbg), 32'(ST_FETCH));
      chk($sformatf("v%0d_n_reg_write", idx), 32'(rw), 32'(v.n_rw));
      chk($sformatf("v%0d_n_mem_write", idx), 32'(mw), 32'(v.n_mw));
      chk($sformatf("v%0d_n_illegal", idx), 32'(ill), 32'(v.n_ill));
      chk($sformatf("v%0d_n_ir_write", idx), 32'(irw), 32'd1);
   endtask

   initial begin
      sarr_t lw_seq;
      lw_seq = '{F, F, D, MA, MR, MR, MB, F};

      vecs.push_back(mk(6'b000000, 6'b100000, 5, '{F,F,D,EX,AW,F,F,F}, 4,
                        kv(0,0,2'b00,3'b010,0,2'b00,0,0,0,1,1,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100010, 5, '{F,F,D,EX,AW,F,F,F}, 3,
                        kv(0,0,2'b00,3'b110,1,2'b00,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100100, 5, '{F,F,D,EX,AW,F,F,F}, 3,
                        kv(0,0,2'b00,3'b000,1,2'b00,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100101, 5, '{F,F,D,EX,AW,F,F,F}, 3,
                        kv(0,0,2'b00,3'b001,1,2'b00,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b101010, 5, '{F,F,D,EX,AW,F,F,F}, 3,
                        kv(0,0,2'b00,3'b111,1,2'b00,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b000000, 6'b100000, 5, '{F,F,D,EX,AW,F,F,F}, 1,
                        kv(1,0,2'b00,3'b010,0,2'b01,0,0,1,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b100011, 6'b000000, 7, lw_seq, 3,
                        kv(0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b100011, 6'b000000, 7, lw_seq, 4,
                        kv(0,0,2'b00,3'b010,0,2'b00,1,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b100011, 6'b000000, 7, lw_seq, 5,
                        kv(0,0,2'b00,3'b010,0,2'b00,1,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b100011, 6'b000000, 7, lw_seq, 6,
                        kv(0,0,2'b00,3'b010,0,2'b00,0,0,0,1,0,1,0), 1, 0, 0));
      vecs.push_back(mk(6'b101011, 6'b000000, 5, '{F,F,D,MA,MW,F,F,F}, 4,
                        kv(0,0,2'b00,3'b010,0,2'b00,1,1,0,0,0,0,0), 0, 1, 0));
      vecs.push_back(mk(6'b101011, 6'b000000, 5, '{F,F,D,MA,MW,F,F,F}, 0,
                        kv(0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0,0), 0, 1, 0));
      vecs.push_back(mk(6'b000100, 6'b000000, 4, '{F,F,D,BR,F,F,F,F}, 3,
                        kv(0,1,2'b01,3'b110,1,2'b00,0,0,0,0,0,0,0), 0, 0, 0));
      vecs.push_back(mk(6'b000100, 6'b101010, 4, '{F,F,D,BR,F,F,F,F}, 2,
                        kv(0,0,2'b00,3'b010,0,2'b11,0,0,0,0,0,0,0), 0, 0, 0));
      vecs.push_back(mk(6'b000010, 6'b000000, 4, '{F,F,D,JP,F,F,F,F}, 3,
                        kv(1,0,2'b10,3'b010,0,2'b00,0,0,0,0,0,0,0), 0, 0, 0));
      vecs.push_back(mk(6'b001000, 6'b000000, 5, '{F,F,D,AE,AB,F,F,F}, 3,
                        kv(0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b001000, 6'b100010, 5, '{F,F,D,AE,AB,F,F,F}, 4,
                        kv(0,0,2'b00,3'b010,0,2'b00,0,0,0,1,0,0,0), 1, 0, 0));
      vecs.push_back(mk(6'b111111, 6'b100000, 3, '{F,F,D,F,F,F,F,F}, 2,
                        kv(0,0,2'b00,3'b010,0,2'b11,0,0,0,0,0,0,1), 0, 0, 1));
      vecs.push_back(mk(6'b000000, 6'b000111, 4, '{F,F,D,EX,F,F,F,F}, 3,
                        kv(0,0,2'b00,3'b010,1,2'b00,0,0,0,0,0,0,1), 0, 0, 1));

      // Reset state and startup sequence with a jump in the IR.
      rst_n = 1'b0; op = 6'b000010; funct = 6'b000000;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", 32'(state_dbg), 32'(ST_FETCH));
      chk("rst_key", 32'(w_key), 32'(kv(0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0,0)));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("c0_state", 32'(state_dbg), 32'(ST_FETCH));
      chk("c0_ir_write", 32'(ir_write), 32'd0);
      chk("c0_iord", 32'(iord), 32'd0);
      @(negedge clk); #1;
      chk("c1_ir_write", 32'(ir_write), 32'd1);
      chk("c1_pc_write", 32'(pc_write), 32'd1);
      chk("c1_alu_src_b", 32'(alu_src_b), 32'd1);
      @(negedge clk); #1;
      chk("c2_state", 32'(state_dbg), 32'(ST_DECODE));
      @(negedge clk); #1;
      chk("c3_state", 32'(state_dbg), 32'(ST_JUMP));
      @(negedge clk);

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // Reset asserted mid-MEMREAD of a load, then the load replays cleanly.
      op = 6'b100011; funct = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rlw_state_c%0d", i), 32'(state_dbg), 32'(lw_seq[i]));
         @(negedge clk);
      end
      #1;
      chk("rlw_memread", 32'(state_dbg), 32'(ST_MEMREAD));
      chk("rlw_memread_iord", 32'(iord), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rlw_async_state", 32'(state_dbg), 32'(ST_FETCH));
      chk("rlw_async_key", 32'(w_key), 32'(kv(0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0,0)));
      @(negedge clk); #1;
      chk("rlw_hold_state", 32'(state_dbg), 32'(ST_FETCH));
      chk("rlw_hold_writes", 32'({mem_write, reg_write}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk($sformatf("rlw_after_state_c%0d", i), 32'(state_dbg), 32'(lw_seq[i]));
         if (i < 6) chk($sformatf("rlw_after_nowr_c%0d", i), 32'({mem_write, reg_write}), 32'd0);
         @(negedge clk);
      end
      #1;
      chk("rlw_after_ret", 32'(state_dbg), 32'(ST_FETCH));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
